// File: rtl/hack_boot_ctrl_if.sv
// Host byte link and instruction-ROM write port of the Hack boot controller.
// The controller takes the slave side; the byte source / ROM model take the master side.
interface hack_boot_ctrl_if #(
  parameter int ROM_AW = 15
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              rom_we;
  logic [ROM_AW-1:0] rom_addr;
  logic [15:0]       rom_wdata;

  modport master (output rx_data, rx_valid, input rx_ready, rom_we, rom_addr, rom_wdata);
  modport slave  (input rx_data, rx_valid, output rx_ready, rom_we, rom_addr, rom_wdata);
endinterface

// File: rtl/hack_boot_ctrl.sv
// Boot/run sequencer for the Hack CPU: streams a program into ROM under CPU reset,
// verifies a mod-256 checksum, then provides run/halt/single-step via cpu_ce.
module hack_boot_ctrl #(
  parameter int ROM_AW   = 15,
  parameter bit AUTO_RUN = 1'b0
) (
  input  logic                clk,
  input  logic                reset_n,
  hack_boot_ctrl_if.slave     bus,
  input  logic                start_load,
  input  logic                run,
  input  logic                halt,
  input  logic                step,
  output logic                cpu_reset,
  output logic                cpu_ce,
  output logic                load_done,
  output logic                load_err,
  output logic [31:0]         cycle_count
);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR_HI, S_HDR_LO, S_DAT_HI, S_DAT_LO, S_CSUM, S_RUN, S_HALT, S_ERROR
  } state_t;

  // A 16-bit header can never exceed the ROM once the ROM holds 2**16 words or more.
  localparam logic [16:0] MAX_WORDS = (ROM_AW >= 16) ? 17'h10000 : 17'(1 << ROM_AW);

  state_t            state, state_nx;
  logic [15:0]       n_words, n_words_nx;
  logic [15:0]       widx, widx_nx;
  logic [7:0]        hi_byte, hi_byte_nx;
  logic [7:0]        csum, csum_nx;
  logic              rx_ready_q, rx_ready_nx;
  logic              rom_we_q, rom_we_nx;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_nx;
  logic [15:0]       rom_wdata_q, rom_wdata_nx;
  logic              cpu_reset_q, cpu_reset_nx;
  logic              cpu_ce_q, cpu_ce_nx;
  logic              load_done_q, load_done_nx;
  logic              load_err_q, load_err_nx;
  logic [31:0]       count_q, count_nx;
  logic              acc;
  logic              step_fire;
  logic [15:0]       hdr_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      n_words     <= '0;
      widx        <= '0;
      hi_byte     <= '0;
      csum        <= '0;
      rx_ready_q  <= 1'b0;
      rom_we_q    <= 1'b0;
      rom_addr_q  <= '0;
      rom_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
      cpu_ce_q    <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      count_q     <= '0;
    end else begin
      state       <= state_nx;
      n_words     <= n_words_nx;
      widx        <= widx_nx;
      hi_byte     <= hi_byte_nx;
      csum        <= csum_nx;
      rx_ready_q  <= rx_ready_nx;
      rom_we_q    <= rom_we_nx;
      rom_addr_q  <= rom_addr_nx;
      rom_wdata_q <= rom_wdata_nx;
      cpu_reset_q <= cpu_reset_nx;
      cpu_ce_q    <= cpu_ce_nx;
      load_done_q <= load_done_nx;
      load_err_q  <= load_err_nx;
      count_q     <= count_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    n_words_nx   = n_words;
    widx_nx      = widx;
    hi_byte_nx   = hi_byte;
    csum_nx      = csum;
    rom_we_nx    = 1'b0;
    rom_addr_nx  = rom_addr_q;
    rom_wdata_nx = rom_wdata_q;
    load_done_nx = load_done_q;
    load_err_nx  = load_err_q;
    count_nx     = cpu_ce_q ? count_q + 32'd1 : count_q;
    step_fire    = 1'b0;
    acc          = bus.rx_valid && rx_ready_q;
    hdr_n        = {hi_byte, bus.rx_data};

    // start_load outranks everything, including a byte accepted on the same edge.
    if (start_load) begin
      state_nx     = S_HDR_HI;
      load_done_nx = 1'b0;
      load_err_nx  = 1'b0;
      widx_nx      = '0;
      csum_nx      = '0;
    end else begin
      if (acc) csum_nx = csum + bus.rx_data;
      unique case (state)
        S_IDLE:   if (run && load_done_q) state_nx = S_RUN;
        S_HDR_HI: if (acc) begin
          hi_byte_nx = bus.rx_data;
          state_nx   = S_HDR_LO;
        end
        S_HDR_LO: if (acc) begin
          n_words_nx = hdr_n;
          widx_nx    = '0;
          if ({1'b0, hdr_n} > MAX_WORDS) begin
            load_err_nx = 1'b1;
            state_nx    = S_ERROR;
          end else if (hdr_n == 16'd0) begin
            state_nx = S_CSUM;
          end else begin
            state_nx = S_DAT_HI;
          end
        end
        S_DAT_HI: if (acc) begin
          hi_byte_nx = bus.rx_data;
          state_nx   = S_DAT_LO;
        end
        S_DAT_LO: if (acc) begin
          rom_we_nx    = 1'b1;
          rom_addr_nx  = ROM_AW'(widx);
          rom_wdata_nx = {hi_byte, bus.rx_data};
          widx_nx      = widx + 16'd1;
          state_nx     = (widx == n_words - 16'd1) ? S_CSUM : S_DAT_HI;
        end
        S_CSUM: if (acc) begin
          if (bus.rx_data == csum) begin
            load_done_nx = 1'b1;
            count_nx     = '0;
            state_nx     = AUTO_RUN ? S_RUN : S_IDLE;
          end else begin
            load_err_nx = 1'b1;
            state_nx    = S_ERROR;
          end
        end
        S_RUN:    if (halt) state_nx = S_HALT;
        // A step pulse landing on the active step cycle is dropped.
        S_HALT:   if (!halt) begin
          if (run) state_nx = S_RUN;
          else if (step && !cpu_ce_q) step_fire = 1'b1;
        end
        S_ERROR:  state_nx = S_ERROR;
        default:  state_nx = S_IDLE;
      endcase
    end

    rx_ready_nx  = state_nx inside {S_HDR_HI, S_HDR_LO, S_DAT_HI, S_DAT_LO, S_CSUM};
    cpu_reset_nx = !(state_nx == S_RUN || state_nx == S_HALT);
    cpu_ce_nx    = (state_nx == S_RUN) || step_fire;
  end

  assign bus.rx_ready  = rx_ready_q;
  assign bus.rom_we    = rom_we_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.rom_wdata = rom_wdata_q;
  assign cpu_reset     = cpu_reset_q;
  assign cpu_ce        = cpu_ce_q;
  assign load_done     = load_done_q;
  assign load_err      = load_err_q;
  assign cycle_count   = count_q;

endmodule

// File: tb/tb_hack_boot_ctrl.sv
// Bench for hack_boot_ctrl: directed load/run scenarios; ROM writes are scored against
// an expectation queue by a negedge monitor, status outputs by direct checks.
module tb_hack_boot_ctrl;
  localparam int AW = 4;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [15:0]   d;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0_n, rst1_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        sel;
  logic        start_load, run, halt, step;
  logic [1:0]  cpu_reset, cpu_ce, load_done, load_err;
  logic [31:0] cyc0, cyc1;

  int  n_vec = 0;
  int  n_err = 0;
  wr_t exp_q[$];
  logic [15:0] wbuf [0:15];

  hack_boot_ctrl_if #(.ROM_AW(AW)) if0 ();
  hack_boot_ctrl_if #(.ROM_AW(AW)) if1 ();

  assign if0.rx_data  = rx_data;
  assign if0.rx_valid = rx_valid && !sel;
  assign if1.rx_data  = rx_data;
  assign if1.rx_valid = rx_valid && sel;

  hack_boot_ctrl #(.ROM_AW(AW), .AUTO_RUN(1'b0)) dut0 (
    .clk(clk), .reset_n(rst0_n), .bus(if0.slave),
    .start_load(start_load && !sel), .run(run && !sel), .halt(halt && !sel), .step(step && !sel),
    .cpu_reset(cpu_reset[0]), .cpu_ce(cpu_ce[0]), .load_done(load_done[0]),
    .load_err(load_err[0]), .cycle_count(cyc0)
  );

  hack_boot_ctrl #(.ROM_AW(AW), .AUTO_RUN(1'b1)) dut1 (
    .clk(clk), .reset_n(rst1_n), .bus(if1.slave),
    .start_load(start_load && sel), .run(run && sel), .halt(halt && sel), .step(step && sel),
    .cpu_reset(cpu_reset[1]), .cpu_ce(cpu_ce[1]), .load_done(load_done[1]),
    .load_err(load_err[1]), .cycle_count(cyc1)
  );

  // Scoreboard monitor: every ROM write from either DUT must match the queue head.
  always @(negedge clk) begin
    wr_t g, e;
    if (if0.rom_we === 1'b1 || if1.rom_we === 1'b1) begin
      g.a = (if0.rom_we === 1'b1) ? if0.rom_addr  : if1.rom_addr;
      g.d = (if0.rom_we === 1'b1) ? if0.rom_wdata : if1.rom_wdata;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rom_write: unexpected write addr=%0h data=%04h, none expected", g.a, g.d);
      end else begin
        e = exp_q.pop_front();
        if (g !== e) begin
          n_err++;
          $display("FAIL rom_write: got addr=%0h data=%04h, expected addr=%0h data=%04h",
                   g.a, g.d, e.a, e.d);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic pulse(input logic [3:0] m);
    {start_load, halt, run, step} = m;
    @(posedge clk); #1;
    {start_load, halt, run, step} = 4'b0000;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int t;
    if (rnd) begin
      while ($urandom_range(0, 1) == 1) begin
        rx_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    rx_data  = b;
    rx_valid = 1'b1;
    t = 0;
    while (!(sel ? if1.rx_ready : if0.rx_ready) && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) begin
      n_vec++;
      n_err++;
      $display("FAIL rx_ready_wait: got ready=0 for 50 cycles, expected ready=1");
    end else begin
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
  endtask

  // Sends header n, the first nsend words of wbuf, and optionally the checksum (+delta).
  task automatic send_stream(input logic [15:0] n, input int nsend, input bit send_cs,
                             input logic [7:0] cs_delta, input bit rnd);
    logic [7:0] cs;
    wr_t e;
    cs = n[15:8] + n[7:0];
    send_byte(n[15:8], rnd);
    send_byte(n[7:0], rnd);
    for (int i = 0; i < nsend; i++) begin
      cs = cs + wbuf[i][15:8] + wbuf[i][7:0];
      send_byte(wbuf[i][15:8], rnd);
      e.a = AW'(i);
      e.d = wbuf[i];
      exp_q.push_back(e);
      send_byte(wbuf[i][7:0], rnd);
    end
    if (send_cs) send_byte(cs + cs_delta, rnd);
  endtask

  task automatic check_reset_vals(input int d);
    if (d == 0) begin
      check("rst cpu_reset", {31'd0, cpu_reset[0]}, 32'd1);
      check("rst cpu_ce", {31'd0, cpu_ce[0]}, 32'd0);
      check("rst rx_ready", {31'd0, if0.rx_ready}, 32'd0);
      check("rst rom_we", {31'd0, if0.rom_we}, 32'd0);
      check("rst load_done", {31'd0, load_done[0]}, 32'd0);
      check("rst load_err", {31'd0, load_err[0]}, 32'd0);
      check("rst cycle_count", cyc0, 32'd0);
      check("rst rom_addr", 32'(if0.rom_addr), 32'd0);
      check("rst rom_wdata", 32'(if0.rom_wdata), 32'd0);
    end else begin
      check("rst1 cpu_reset", {31'd0, cpu_reset[1]}, 32'd1);
      check("rst1 cpu_ce", {31'd0, cpu_ce[1]}, 32'd0);
      check("rst1 rx_ready", {31'd0, if1.rx_ready}, 32'd0);
      check("rst1 rom_we", {31'd0, if1.rom_we}, 32'd0);
      check("rst1 load_done", {31'd0, load_done[1]}, 32'd0);
      check("rst1 load_err", {31'd0, load_err[1]}, 32'd0);
      check("rst1 cycle_count", cyc1, 32'd0);
      check("rst1 rom_addr", 32'(if1.rom_addr), 32'd0);
      check("rst1 rom_wdata", 32'(if1.rom_wdata), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst0_n = 1'b0; rst1_n = 1'b0;
    rx_data = 8'h00; rx_valid = 1'b0; sel = 1'b0;
    {start_load, halt, run, step} = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals(0);
    rst0_n = 1'b1; rst1_n = 1'b1;
    @(posedge clk); #1;

    // Good 2-word load; checksum 00+02+12+34+AB+CD = 0xC0.
    wbuf[0] = 16'h1234; wbuf[1] = 16'hABCD;
    pulse(4'b1000);
    check("t1 rx_ready", {31'd0, if0.rx_ready}, 32'd1);
    send_stream(16'd2, 2, 1'b1, 8'h00, 1'b0);
    check("t1 load_done", {31'd0, load_done[0]}, 32'd1);
    check("t1 load_err", {31'd0, load_err[0]}, 32'd0);
    check("t1 rx_ready idle", {31'd0, if0.rx_ready}, 32'd0);
    check("t1 cpu_reset idle", {31'd0, cpu_reset[0]}, 32'd1);

    // Bad checksum (0xC1) -> ERROR; run/step/halt ignored.
    pulse(4'b1000);
    check("t2 done cleared", {31'd0, load_done[0]}, 32'd0);
    send_stream(16'd2, 2, 1'b1, 8'h01, 1'b0);
    check("t2 load_err", {31'd0, load_err[0]}, 32'd1);
    check("t2 load_done", {31'd0, load_done[0]}, 32'd0);
    pulse(4'b0010);
    pulse(4'b0001);
    pulse(4'b0100);
    check("t2 cpu_reset", {31'd0, cpu_reset[0]}, 32'd1);
    check("t2 cpu_ce", {31'd0, cpu_ce[0]}, 32'd0);
    check("t2 err held", {31'd0, load_err[0]}, 32'd1);

    // Run 10 cycles, halt, then single steps.
    pulse(4'b1000);
    send_stream(16'd2, 2, 1'b1, 8'h00, 1'b0);
    pulse(4'b0010);
    check("t3 run ce", {31'd0, cpu_ce[0]}, 32'd1);
    check("t3 run cpu_reset", {31'd0, cpu_reset[0]}, 32'd0);
    repeat (9) @(posedge clk);
    #1;
    pulse(4'b0100);
    check("t3 halt ce", {31'd0, cpu_ce[0]}, 32'd0);
    check("t3 count after run", cyc0, 32'd10);
    for (int i = 0; i < 3; i++) begin
      pulse(4'b0001);
      check("t3 step ce on", {31'd0, cpu_ce[0]}, 32'd1);
      @(posedge clk); #1;
      check("t3 step ce off", {31'd0, cpu_ce[0]}, 32'd0);
    end
    check("t3 count after steps", cyc0, 32'd13);
    step = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    step = 1'b0;
    check("t3 held step single", {31'd0, cpu_ce[0]}, 32'd0);
    check("t3 count held step", cyc0, 32'd14);
    check("t3 cpu_reset halt", {31'd0, cpu_reset[0]}, 32'd0);
    pulse(4'b0110);
    check("t3 halt beats run", {31'd0, cpu_ce[0]}, 32'd0);
    pulse(4'b0010);
    check("t3 resume", {31'd0, cpu_ce[0]}, 32'd1);
    pulse(4'b0110);
    check("t3 halt beats run in run", {31'd0, cpu_ce[0]}, 32'd0);
    pulse(4'b0010);
    pulse(4'b1000);
    check("t3 abort cpu_reset", {31'd0, cpu_reset[0]}, 32'd1);
    check("t3 abort ce", {31'd0, cpu_ce[0]}, 32'd0);
    check("t3 abort rx_ready", {31'd0, if0.rx_ready}, 32'd1);

    // Header of 17 words exceeds a 16-word ROM.
    send_byte(8'h00, 1'b0);
    send_byte(8'h11, 1'b0);
    check("t4 len err", {31'd0, load_err[0]}, 32'd1);
    check("t4 rx_ready", {31'd0, if0.rx_ready}, 32'd0);
    // Exactly 16 words is legal; the last write lands on address 15.
    for (int i = 0; i < 16; i++) wbuf[i] = 16'(16'h1111 * i + 16'h0F00);
    pulse(4'b1000);
    send_stream(16'd16, 16, 1'b1, 8'h00, 1'b0);
    check("t4 full load_done", {31'd0, load_done[0]}, 32'd1);
    check("t4 count cleared", cyc0, 32'd0);
    pulse(4'b1000);
    send_stream(16'd0, 0, 1'b1, 8'h00, 1'b0);
    check("t4 empty load_done", {31'd0, load_done[0]}, 32'd1);

    // Abort after one word, then a fresh load; also drop a byte that collides with start_load.
    wbuf[0] = 16'h0F0F; wbuf[1] = 16'h5AA5;
    pulse(4'b1000);
    send_stream(16'd2, 1, 1'b0, 8'h00, 1'b0);
    pulse(4'b1000);
    check("t5 abort cpu_reset", {31'd0, cpu_reset[0]}, 32'd1);
    check("t5 abort rx_ready", {31'd0, if0.rx_ready}, 32'd1);
    check("t5 abort done", {31'd0, load_done[0]}, 32'd0);
    rx_data = 8'h07; rx_valid = 1'b1; start_load = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; start_load = 1'b0;
    send_stream(16'd2, 2, 1'b1, 8'h00, 1'b0);
    check("t5 reload done", {31'd0, load_done[0]}, 32'd1);
    check("t5 reload err", {31'd0, load_err[0]}, 32'd0);

    // AUTO_RUN device with ragged rx_valid, async reset mid-DAT_LO, then reload.
    sel = 1'b1;
    wbuf[0] = 16'hBEEF; wbuf[1] = 16'hC0DE;
    pulse(4'b1000);
    send_stream(16'd2, 2, 1'b1, 8'h00, 1'b1);
    check("t6 auto run ce", {31'd0, cpu_ce[1]}, 32'd1);
    check("t6 auto run cpu_reset", {31'd0, cpu_reset[1]}, 32'd0);
    pulse(4'b1000);
    send_stream(16'd2, 0, 1'b0, 8'h00, 1'b1);
    send_byte(8'hBE, 1'b1);
    #2;
    rst1_n = 1'b0;
    #1;
    check_reset_vals(1);
    @(posedge clk); #1;
    rst1_n = 1'b1;
    @(posedge clk); #1;
    pulse(4'b1000);
    send_stream(16'd2, 2, 1'b1, 8'h00, 1'b1);
    check("t6 reload done", {31'd0, load_done[1]}, 32'd1);
    check("t6 reload ce", {31'd0, cpu_ce[1]}, 32'd1);
    check("t6 reload cpu_reset", {31'd0, cpu_reset[1]}, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("t6 count", cyc1, 32'd5);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
